// File: rtl/lbctrl_pkg.sv
// Shared types and constants for the 3x3 line-buffer read controller.
// Holds the FSM states, the width-code table and the window tag layout.
package lbctrl_pkg;

  typedef enum logic [1:0] {IDLE, FILL, DRAIN, DONE} state_t;

  localparam logic [2:0] SEL_MAX = 3'd5;

  typedef struct packed {
    logic       valid;
    logic [7:0] row;
    logic [7:0] col;
    logic       last;
  } tag_t;

  // Width code 0..5 maps to 8..256; 9 bits so W=256 is representable.
  function automatic logic [8:0] sel_to_w(input logic [2:0] sel);
    case (sel)
      3'd0:    sel_to_w = 9'd8;
      3'd1:    sel_to_w = 9'd16;
      3'd2:    sel_to_w = 9'd32;
      3'd3:    sel_to_w = 9'd64;
      3'd4:    sel_to_w = 9'd128;
      3'd5:    sel_to_w = 9'd256;
      default: sel_to_w = 9'd8;
    endcase
  endfunction

endpackage

// File: rtl/linebuffer_3x3_ctrl_tag_pipe.sv
// lbctrl_tag_pipe: DEPTH-cycle shift of window tags, aligning them with line-buffer output.
// Latency DEPTH cycles; free-running, no backpressure.
module lbctrl_tag_pipe
  import lbctrl_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  tag_t tag_in,
  output tag_t tag_out
);

  tag_t stage [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/linebuffer_3x3_ctrl.sv
// Frame read sequencer for a 3x3 line buffer: streams W*W reads and tags legal windows PIPE_LAT cycles later.
// No backpressure; optional stride-2 window decimation under LBCTRL_STRIDE2_EN.
module linebuffer_3x3_ctrl
  import lbctrl_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int PIPE_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        cfg_sel,
`ifdef LBCTRL_STRIDE2_EN
  input  logic              cfg_stride2,
`endif
  output logic              busy,
  output logic              done,
  output logic              cfg_err,
  output logic [2:0]        lb_sel,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              win_valid,
  output logic [7:0]        win_row,
  output logic [7:0]        win_col,
  output logic              win_last
);

  localparam logic [3:0] DRAIN_LAST = 4'(PIPE_LAT - 1);

  state_t     state, state_nxt;
  logic [8:0] w_q;
  logic [8:0] row, col;
  logic [3:0] drain_cnt;
  logic       start_ok, start_bad, last_px;
  tag_t       tag_d, tag_q;
`ifdef LBCTRL_STRIDE2_EN
  logic       stride2_q;
`endif

  assign start_ok  = (state == IDLE) && start && (cfg_sel <= SEL_MAX);
  assign start_bad = (state == IDLE) && start && (cfg_sel >  SEL_MAX);
  assign last_px   = (row == w_q - 9'd1) && (col == w_q - 9'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    rd_en     = 1'b0;
    case (state)
      IDLE:  if (start_ok) state_nxt = FILL;
      FILL: begin
        busy  = 1'b1;
        rd_en = 1'b1;
        if (last_px) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (drain_cnt == DRAIN_LAST) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q       <= 9'd8;
      lb_sel    <= '0;
      row       <= '0;
      col       <= '0;
      rd_addr   <= '0;
      drain_cnt <= '0;
      cfg_err   <= 1'b0;
`ifdef LBCTRL_STRIDE2_EN
      stride2_q <= 1'b0;
`endif
    end else begin
      cfg_err <= start_bad;
      if (start_ok) begin
        w_q     <= sel_to_w(cfg_sel);
        lb_sel  <= cfg_sel;
        row     <= '0;
        col     <= '0;
        rd_addr <= '0;
`ifdef LBCTRL_STRIDE2_EN
        stride2_q <= cfg_stride2;
`endif
      end
      if (state == FILL) begin
        // Address holds on the final pixel so it reads W*W-1 after the frame.
        if (!last_px) rd_addr <= rd_addr + ADDR_W'(1);
        if (col == w_q - 9'd1) begin
          col <= '0;
          row <= row + 9'd1;
        end else begin
          col <= col + 9'd1;
        end
      end
      drain_cnt <= (state == DRAIN) ? drain_cnt + 4'd1 : 4'd0;
    end
  end

  // A window is complete once its bottom-right pixel is read; c<2 straddles a row wrap.
  always_comb begin
    tag_d       = '0;
    tag_d.valid = rd_en && (row >= 9'd2) && (col >= 9'd2);
    tag_d.last  = rd_en && last_px;
`ifdef LBCTRL_STRIDE2_EN
    if (stride2_q) begin
      tag_d.valid = tag_d.valid && !row[0] && !col[0];
      tag_d.last  = rd_en && (row == w_q - 9'd2) && (col == w_q - 9'd2);
    end
`endif
    if (tag_d.valid) begin
      tag_d.row = row[7:0] - 8'd2;
      tag_d.col = col[7:0] - 8'd2;
    end
  end

  lbctrl_tag_pipe #(
    .DEPTH (PIPE_LAT)
  ) u_tag_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .tag_in  (tag_d),
    .tag_out (tag_q)
  );

  assign win_valid = tag_q.valid;
  assign win_row   = tag_q.row;
  assign win_col   = tag_q.col;
  assign win_last  = tag_q.last;

endmodule

// File: tb/tb_linebuffer_3x3_ctrl.sv
// Scoreboard bench for linebuffer_3x3_ctrl: expected windows queued per frame, monitor pops on win_valid.
`timescale 1ns/1ps
module tb_linebuffer_3x3_ctrl;

  localparam int ADDR_W   = 16;
  localparam int PIPE_LAT = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [2:0]        cfg_sel = 3'd0;
`ifdef LBCTRL_STRIDE2_EN
  logic              cfg_stride2 = 1'b0;
`endif
  logic              busy, done, cfg_err, rd_en, win_valid, win_last;
  logic [2:0]        lb_sel;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        win_row, win_col;

  typedef struct packed {
    logic [7:0] row;
    logic [7:0] col;
    logic       last;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   win_cnt = 0;
  bit   prev_rd = 1'b0;
  int   last_addr_seen = 0;

  always #5 clk = ~clk;

  linebuffer_3x3_ctrl #(
    .ADDR_W   (ADDR_W),
    .PIPE_LAT (PIPE_LAT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .cfg_sel     (cfg_sel),
`ifdef LBCTRL_STRIDE2_EN
    .cfg_stride2 (cfg_stride2),
`endif
    .busy        (busy),
    .done        (done),
    .cfg_err     (cfg_err),
    .lb_sel      (lb_sel),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .win_valid   (win_valid),
    .win_row     (win_row),
    .win_col     (win_col),
    .win_last    (win_last)
  );

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: windows against the scoreboard, read addresses for contiguity.
  always @(negedge clk) begin
    if (rst_n) begin
      if (win_valid) begin
        chk("win_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          chk("win_row",  int'(win_row),  int'(mon_e.row));
          chk("win_col",  int'(win_col),  int'(mon_e.col));
          chk("win_last", int'(win_last), int'(mon_e.last));
        end
        win_cnt++;
      end else begin
        chk("win_last_without_valid", int'(win_last), 0);
      end
      if (rd_en) begin
        chk("rd_addr", int'(rd_addr), prev_rd ? last_addr_seen + 1 : 0);
        last_addr_seen = int'(rd_addr);
      end
      prev_rd = rd_en;
    end else begin
      prev_rd = 1'b0;
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},      int'(busy),      0);
    chk({tag, "_done"},      int'(done),      0);
    chk({tag, "_cfg_err"},   int'(cfg_err),   0);
    chk({tag, "_lb_sel"},    int'(lb_sel),    0);
    chk({tag, "_rd_en"},     int'(rd_en),     0);
    chk({tag, "_rd_addr"},   int'(rd_addr),   0);
    chk({tag, "_win_valid"}, int'(win_valid), 0);
    chk({tag, "_win_row"},   int'(win_row),   0);
    chk({tag, "_win_col"},   int'(win_col),   0);
    chk({tag, "_win_last"},  int'(win_last),  0);
  endtask

  // inj_at: read index at which a stray start (cfg_sel=2) is pulsed; rst_at: read index at which reset hits.
  task automatic run_frame(input int sel, input bit s2, input int inj_at, input int rst_at);
    int w, nrd, first_rd, last_rd, first_win, done_cyc, w0, exp_n, act_cnt;
    bit inj_clr, saw_err;
    w = 8 << sel;
    nrd = 0; first_rd = -1; last_rd = -1; first_win = -1; done_cyc = -1;
    w0 = win_cnt; exp_n = 0; inj_clr = 1'b0; saw_err = 1'b0;
    for (int r = 2; r < w; r++) begin
      for (int c = 2; c < w; c++) begin
        int wr, wc;
        bit lst;
        wr = r - 2;
        wc = c - 2;
        if (s2 && (((wr % 2) != 0) || ((wc % 2) != 0))) continue;
        lst = s2 ? (wr == w - 4 && wc == w - 4) : (r == w - 1 && c == w - 1);
        exp_q.push_back('{8'(wr), 8'(wc), lst});
        exp_n++;
      end
    end
    cfg_sel = 3'(sel);
`ifdef LBCTRL_STRIDE2_EN
    cfg_stride2 = s2;
`endif
    start = 1'b1;
    for (int k = 0; k < w * w + 40; k++) begin
      @(negedge clk);
      if (k == 0) begin
        start = 1'b0;
        chk("busy_after_start", int'(busy), 1);
      end
      if (inj_clr) begin
        start   = 1'b0;
        cfg_sel = 3'(sel);
        inj_clr = 1'b0;
      end
      saw_err = saw_err | cfg_err;
      if (win_valid && first_win < 0) first_win = k;
      if (rd_en) begin
        if (first_rd < 0) first_rd = k;
        last_rd = k;
        nrd++;
        if (nrd == inj_at) begin
          start   = 1'b1;
          cfg_sel = 3'd2;
          inj_clr = 1'b1;
        end
        if (nrd == rst_at) begin
          #2 rst_n = 1'b0;
          exp_q.delete();
          #1 chk_all_zero("rst_mid");
          repeat (2) @(negedge clk);
          rst_n = 1'b1;
          act_cnt = 0;
          repeat (12) begin
            @(negedge clk);
            act_cnt += int'(done) + int'(win_valid) + int'(rd_en) + int'(busy);
          end
          chk("activity_after_rst", act_cnt, 0);
          return;
        end
      end
      if (done) begin
        done_cyc = k;
        break;
      end
    end
    chk("done_seen", int'(done_cyc >= 0), 1);
    if (done_cyc >= 0) begin
      chk("busy_at_done",  int'(busy), 0);
      chk("rd_count",      nrd, w * w);
      chk("rd_gapless",    last_rd - first_rd + 1, w * w);
      chk("first_rd_cyc",  first_rd, 0);
      chk("done_cyc",      done_cyc, w * w + PIPE_LAT);
      chk("first_win_cyc", first_win, 2 * w + 2 + PIPE_LAT);
      chk("win_count",     win_cnt - w0, exp_n);
      chk("queue_drained", exp_q.size(), 0);
      chk("lb_sel_frame",  int'(lb_sel), sel);
      chk("last_rd_addr",  last_addr_seen, w * w - 1);
      chk("cfg_err_frame", int'(saw_err), 0);
      // Start during DONE must be ignored.
      start   = 1'b1;
      cfg_sel = 3'd3;
      @(negedge clk);
      start = 1'b0;
      chk("done_width",       int'(done),   0);
      chk("start_in_done",    int'(busy),   0);
      chk("lb_sel_after",     int'(lb_sel), sel);
      chk("cfg_err_in_done",  int'(cfg_err), 0);
    end else begin
      exp_q.delete();
    end
  endtask

  initial begin
    int rd_seen;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    run_frame(0, 1'b0, -1, -1);

    cfg_sel = 3'd6;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("cfg_err_pulse", int'(cfg_err), 1);
    chk("cfg_err_busy",  int'(busy),    0);
    rd_seen = 0;
    repeat (8) begin
      @(negedge clk);
      rd_seen += int'(rd_en) + int'(cfg_err) + int'(busy);
    end
    chk("cfg_err_idle", rd_seen, 0);

    run_frame(1, 1'b0, 30, -1);
    run_frame(0, 1'b0, -1, 20);
    run_frame(0, 1'b0, -1, -1);
`ifdef LBCTRL_STRIDE2_EN
    run_frame(1, 1'b1, -1, -1);
`endif
    run_frame(5, 1'b0, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
